// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and defaults for the SPI master sequencer.
package spi_master_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD
  } spi_state_t;

  localparam int SPI_CLK_DIV_DEF  = 50;
  localparam int SPI_CS_SETUP_DEF = 10;
  localparam int SPI_BITS         = 8;

endpackage

// File: rtl/spi_phase_cnt.sv
// Phase timer: load with a length L, expire is high on the L-th cycle after the load.
// One-cycle registered latency from load; no backpressure.
module spi_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 byte sequencer: start strobe in, busy/done/ovr status out; all outputs registered.
// Starts while busy are dropped and flagged on ovr. SPI_MASTER_CTRL_LOOPBACK_EN adds a loopback port.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = SPI_CLK_DIV_DEF,
  parameter int CS_SETUP_CYC = SPI_CS_SETUP_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] wr_data,
  input  logic       wr_stb,
  input  logic       cs_hold,
  input  logic       cs_release,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ovr,
  output logic       spi_cs,
  output logic       spi_clk,
  output logic       spi_sdi,
  input  logic       spi_sdo
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  ,
  input  logic       loopback
`endif
);

  localparam int MAX_PHASE = (CLK_DIV > CS_SETUP_CYC) ? CLK_DIV : CS_SETUP_CYC;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

  spi_state_t          state_q, state_d;
  logic [SPI_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                sdi_q, sdi_d;
  logic                hold_q, hold_d;

  logic                ph_load;
  logic [CNT_W-1:0]    ph_len;
  logic                ph_expire;
  logic                lb;
  logic                sample_bit;

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  assign sample_bit = lb ? sdi_q : spi_sdo;

  spi_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ph_load),
    .load_val (ph_len),
    .expire   (ph_expire)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    hold_d    = hold_q;
    ph_load   = 1'b0;
    ph_len    = CNT_W'(CLK_DIV);

    unique case (state_q)
      IDLE: begin
        // A start beats a same-cycle release, so a held CS skips SETUP.
        if (wr_stb) begin
          shreg_d   = wr_data;
          sdi_d     = wr_data[7];
          busy_d    = 1'b1;
          hold_d    = cs_hold;
          bit_cnt_d = '0;
          ph_load   = 1'b1;
          if (cs_q) begin
            cs_d    = 1'b0;
            ph_len  = CNT_W'(CS_SETUP_CYC);
            state_d = SETUP;
          end else begin
            state_d = LOW;
          end
        end else if (cs_release) begin
          cs_d = 1'b1;
        end
      end
      SETUP, LOW: begin
        if (ph_expire) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[SPI_BITS-2:0], sample_bit};
          ph_load = 1'b1;
        end
      end
      HIGH: begin
        if (ph_expire) begin
          sclk_d  = 1'b0;
          ph_load = 1'b1;
          if (bit_cnt_q < LAST_BIT) begin
            state_d   = LOW;
            sdi_d     = shreg_q[SPI_BITS-1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ph_expire) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rd_data_d = shreg_q;
          if (!hold_q) begin
            cs_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && wr_stb) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      rd_data_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      sdi_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      sdi_q     <= sdi_d;
      hold_q    <= hold_d;
    end
  end

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  // Pin-side CS is masked in loopback while cs_q keeps tracking the real protocol state.
  logic cs_pin_q, cs_pin_d;

  assign cs_pin_d = cs_d | lb;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_pin_q <= 1'b1;
    end else begin
      cs_pin_q <= cs_pin_d;
    end
  end

  assign spi_cs = cs_pin_q;
`else
  assign spi_cs = cs_q;
`endif

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovr     = ovr_q;
  assign spi_clk = sclk_q;
  assign spi_sdi = sdi_q;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Hardware SPI master sequencer for the PicoBlaze I/O space, replacing bit-banged SPI over output ports. The processor writes one byte with a start strobe. The block then asserts chip select, shifts the byte out MSB-first on `spi_sdi` while shifting `spi_sdo` in, and returns the received byte with busy/done status. It uses SPI mode 0: `spi_clk` idles low, data changes on the falling edge, and input is sampled on the rising edge.

## Interface
- `CLK_DIV`, default 50: `spi_clk` half-period in `clk` cycles (1 MHz at 100 MHz). Legal range ≥2.
- `CS_SETUP_CYC`, default 10: cycles from CS falling to the first `spi_clk` rising edge. Legal range ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `wr_data`  in  8  byte to transmit, sampled on an accepted start.
- `wr_stb`  in  1  start request, one cycle.
- `cs_hold`  in  1  sampled with start: 1 keeps CS asserted after the byte.
- `cs_release`  in  1  one-cycle pulse: deassert a held CS while idle.
- `rd_data`  out  8  last received byte.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer end.
- `ovr`  out  1  one-cycle pulse: start rejected while busy.
- `spi_cs`  out  1  chip select, active low.
- `spi_clk`  out  1  serial clock.
- `spi_sdi`  out  1  serial data to slave.
- `spi_sdo`  in  1  serial data from slave.

## Operation
- **Reset values:** `spi_cs`=1, `spi_clk`=0, `spi_sdi`=0, `rd_data`=0, `busy`=0, `done`=0, `ovr`=0; state IDLE.
- **States:** IDLE, SETUP, LOW, HIGH, HOLD. A counter `cnt` sets each phase length; `bit_cnt` runs 0..7.
- **IDLE with `wr_stb`=1:**
  - Load `shreg`=`wr_data`; `spi_sdi`=`wr_data[7]`; `busy`=1; latch `cs_hold`.
  - If `spi_cs`=1: set `spi_cs`=0 and go to SETUP for `CS_SETUP_CYC` cycles.
  - If `spi_cs` is already 0 (held): go to LOW for `CLK_DIV` cycles.
- **SETUP or LOW expiry:** go to HIGH; `spi_clk`=1; `shreg`={`shreg[6:0]`,`spi_sdo`}.
- **HIGH expiry:**
  - If `bit_cnt`<7: go to LOW; `spi_clk`=0; `spi_sdi`=`shreg[7]`; increment `bit_cnt`.
  - Otherwise: go to HOLD; `spi_clk`=0.
- **HOLD expiry** (`CLK_DIV` cycles): go to IDLE.
  - Set `busy`=0, `done`=1, `rd_data`=`shreg`.
  - Set `spi_cs`=1 unless the latched `cs_hold`=1.
  - `spi_sdi` keeps its last value.
- **Start while busy:** ignored; `ovr` pulses the next cycle; the transfer is unaffected.
- **`cs_release`:** honoured only in IDLE (`spi_cs`←1 next cycle); ignored while busy.
- **Same-cycle `wr_stb` and `cs_release` in IDLE:** start wins, the release is dropped, and CS stays low, so SETUP is skipped.
- **Reset mid-transfer:** all outputs return to reset values on the next edge. No `done` pulse is issued, and `rd_data` is cleared.

## Timing
- The start is sampled at edge N. `busy`, `spi_cs`, and the first `spi_sdi` bit change at edge N+1.
- `busy` high time:
  - `CS_SETUP_CYC`+16·`CLK_DIV` cycles from deasserted CS.
  - 17·`CLK_DIV` cycles from held CS.
- `done` is asserted in the same cycle `busy` falls. `rd_data` is valid from that cycle until the next `done`.
- A new start is accepted in the first cycle `busy`=0.
- `spi_sdo` is registered at the same `clk` edge that drives `spi_clk` high. The slave must hold `spi_sdo` stable for the preceding half period.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- **Macro `SPI_MASTER_CTRL_LOOPBACK_EN`:**
  - Adds input port `loopback` (1 bit).
  - When `loopback`=1: the shift register samples `spi_sdi` instead of `spi_sdo`, and `spi_cs` is forced to 1, so no slave is selected.
  - Internal CS tracking is unchanged.
- **Without the macro:** the port is absent and `spi_sdo` is always sampled.

## Structure
- **Package `spi_master_ctrl_pkg`:**
  - state enum `spi_state_t` {IDLE, SETUP, LOW, HIGH, HOLD}
  - default constants `SPI_CLK_DIV_DEF`=50 and `SPI_CS_SETUP_DEF`=10
  - `SPI_BITS`=8
- **Sub-module `spi_phase_cnt`:** a down-counter loaded with a phase length that asserts `expire` at 0. It is the natural single sub-module; everything else stays in `spi_master_ctrl`.

## Test plan
- **Basic byte:** `CLK_DIV`=4, `CS_SETUP_CYC`=2; write 0xA5 with the slave model returning 0x3C → `spi_sdi` bits 1,0,1,0,0,1,0,1 across the rising edges; `rd_data`=0x3C; `busy` high 66 cycles; one `done` pulse; `spi_cs` back to 1.
- **Held CS:** write 0x81 with `cs_hold`=1, then 0x7E with `cs_hold`=0 → CS stays low between bytes; second `busy` is 68 cycles; CS rises with the second `done`.
- **Overrun:** `wr_stb` with 0xFF at cycle 10 of a 0x00 transfer → `ovr` pulses once; `spi_sdi` stays 0 for all 8 bits; `rd_data` reflects the first transfer only.
- **Reset mid-transfer:** `reset_n`=0 after the 3rd rising `spi_clk` → next edge has `spi_cs`=1, `spi_clk`=0, `busy`=0, `rd_data`=0, no `done`; a fresh 0x5A transfer afterwards completes correctly.
- **Release race:** `cs_release` alone while idle with CS held → `spi_cs`=1 next cycle. `cs_release`+`wr_stb` in the same cycle → transfer starts without SETUP and CS stays low.
- **Loopback (macro on):** `loopback`=1, write 0xC3 → `rd_data`=0xC3, `spi_cs` stays 1 throughout.
